mti_integrator: RTL and testbench

MTI_INTEGRATOR -- requirements
Module: mti_integrator

---
 rtl/mti_integrator.sv | 75 +++++++
 tb/tb_mti_integrator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mti_integrator.sv
// mti_integrator: per-bin pulse-to-pulse integrator, the exact inverse of a 2-pulse MTI canceller.
// Define MTI_INTEG_LEAK_EN to build a leaky integrator (acc - acc>>>LEAK_SHIFT + diff) instead.
module mti_integrator #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BINS   = 64,
  parameter int LEAK_SHIFT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [15:0]           pulse_count,
  output logic                  seeding
);
  localparam int BW = $clog2(NUM_BINS);
  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
  state_t                r_state;
  logic [BW-1:0]         r_bin;
  logic [DATA_WIDTH-1:0] r_acc [NUM_BINS];
  logic [DATA_WIDTH-1:0] r_out;
  logic                  r_valid;
  logic [15:0]           r_pc;
  logic                  w_accept;
  logic                  w_wrap;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_new;
  assign data_ready     = enable && r_state != IDLE && (!r_valid || data_out_ready);
  assign w_accept       = data_valid && data_ready;
  assign w_wrap         = r_bin == BW'(NUM_BINS - 1);
  assign w_cur          = r_acc[r_bin];
  assign data_out       = r_out;
  assign data_out_valid = r_valid;
  assign pulse_count    = r_pc;
  assign seeding        = r_state == SEED;
`ifdef MTI_INTEG_LEAK_EN
  // separate signed net so the shift stays arithmetic inside the unsigned sum
  logic signed [DATA_WIDTH-1:0] w_leak;
  assign w_leak = $signed(w_cur) >>> LEAK_SHIFT;
  assign w_new  = r_state == SEED ? data_in : w_cur - w_leak + data_in;
`else
  assign w_new  = r_state == SEED ? data_in : w_cur + data_in;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      for (int i = 0; i < NUM_BINS; i++) r_acc[i] <= '0;
    end else if (start) begin
      r_state <= SEED;
      r_bin   <= '0;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc[r_bin] <= w_new;
      r_out        <= w_new;
      r_valid      <= 1'b1;
      r_bin        <= r_bin + 1'b1;
      if (w_wrap) begin
        r_pc    <= r_pc + 16'(r_pc != 16'hFFFF);
        r_state <= RUN;
      end
    end else if (data_out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mti_integrator.sv
// tb_mti_integrator: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mti_integrator;
  localparam int NB = 4;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        enable = 1;
  logic        start = 0;
  logic [15:0] data_in = 0;
  logic        data_valid = 0;
  logic        data_ready;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1;
  logic [15:0] pulse_count;
  logic        seeding;
  int checks = 0;
  int errors = 0;
  int stalls = 0;
  logic [15:0] q_log[$];
  int          m_state = 0;
  int          m_bin = 0;
  int          m_pc = 0;
  bit          m_has_out = 0;
  logic [15:0] m_out = 0;
  logic [15:0] m_acc [NB];

  mti_integrator #(.DATA_WIDTH(16), .NUM_BINS(NB), .LEAK_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .pulse_count(pulse_count), .seeding(seeding));

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return enable && m_state != 0 && (!m_has_out || data_out_ready);
  endfunction

  // seed stores the raw sample; run adds the difference (optionally leaking)
  function automatic logic [15:0] next_val(logic [15:0] a, logic [15:0] d, int st);
    logic signed [15:0] leak;
    leak = $signed(a) >>> 4;
    if (st == 1) return d;
`ifdef MTI_INTEG_LEAK_EN
    return a - leak + d;
`else
    return a + d;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_bin <= 0; m_pc <= 0; m_has_out <= 0; m_out <= 0;
      for (int i = 0; i < NB; i++) m_acc[i] <= 0;
    end else if (start) begin
      m_state <= 1; m_bin <= 0; m_pc <= 0; m_has_out <= 0;
    end else if (data_valid && exp_ready()) begin
      m_acc[m_bin] <= next_val(m_acc[m_bin], data_in, m_state);
      m_out <= next_val(m_acc[m_bin], data_in, m_state);
      m_has_out <= 1;
      m_bin <= (m_bin + 1) % NB;
      if (m_bin == NB - 1) begin
        m_pc <= (m_pc == 65535) ? m_pc : m_pc + 1;
        if (m_state == 1) m_state <= 2;
      end
    end else if (data_out_ready) begin
      m_has_out <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks += 4;
      if (data_ready !== exp_ready()) begin errors++; $display("FAIL cyc data_ready got %0b want %0b t=%0t", data_ready, exp_ready(), $time); end
      if (data_out_valid !== m_has_out) begin errors++; $display("FAIL cyc data_out_valid got %0b want %0b t=%0t", data_out_valid, m_has_out, $time); end
      if (pulse_count !== 16'(m_pc)) begin errors++; $display("FAIL cyc pulse_count got %0d want %0d t=%0t", pulse_count, m_pc, $time); end
      if (seeding !== (m_state == 1)) begin errors++; $display("FAIL cyc seeding got %0b want %0b t=%0t", seeding, m_state == 1, $time); end
      if (m_has_out) begin
        checks++;
        if (data_out !== m_out) begin errors++; $display("FAIL cyc data_out got %0h want %0h t=%0t", data_out, m_out, $time); end
      end
      if (data_out_valid && data_out_ready) q_log.push_back(data_out);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s got %0d want %0d", nm, act, exp); end
  endtask

  task automatic send(input logic [15:0] v);
    int n = 0;
    data_in = v; data_valid = 1;
    @(negedge clk);
    while (!data_ready && n < 50) begin n++; @(negedge clk); end
    stalls += n;
    if (!data_ready) begin errors++; $display("FAIL send_timeout ready got 0 want 1"); end
    @(posedge clk); #1;
    data_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string nm, input logic [15:0] exp[$]);
    chk({nm, "_len"}, q_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < q_log.size(); i++) chk($sformatf("%s[%0d]", nm, i), q_log[i], exp[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_pc", pulse_count, 0);
    chk("rst_seeding", seeding, 0);
    chk("rst_ready", data_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    data_valid = 1; data_in = 16'h1234;
    repeat (3) begin @(negedge clk); chk("idle_ready", data_ready, 0); end
    @(posedge clk); #1;
    data_valid = 0;
    // basic seed then integrate
    q_log.delete();
    pulse_start();
    send(10); send(20); send(30); send(40);
    @(negedge clk);
    chk("pc_after_seed", pulse_count, 1);
    chk("seed_done", seeding, 0);
    @(posedge clk); #1;
    send(1); send(2); send(3); send(4);
    drain();
    chk("pc_after_run", pulse_count, 2);
    chk_log("basic", '{16'd10, 16'd20, 16'd30, 16'd40, 16'd11, 16'd22, 16'd33, 16'd44});
    // modulo wrap
    pulse_start();
    q_log.delete();
    send(16'hFFFF); send(0); send(0); send(0); send(2);
    drain();
    chk("wrap_out", q_log.size() > 4 ? q_log[4] : 16'hDEAD, 1);
    // backpressure then full-rate release
    q_log.delete();
    data_out_ready = 0;
    send(5);
    data_in = 6; data_valid = 1;
    @(negedge clk);
    held = data_out;
    chk("bp_held", held, 5);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", data_ready, 0);
      chk("bp_stable", data_out, held);
      chk("bp_valid", data_out_valid, 1);
    end
    @(posedge clk); #1;
    data_out_ready = 1;
    stalls = 0;
    send(6); send(7); send(8); send(9);
    chk("bp_stalls", stalls, 0);
    drain();
    chk_log("bp", '{16'd5, 16'd6, 16'd7, 16'd9, 16'd14});
    // start collides with an accept at bin 2
    q_log.delete();
    data_in = 99; data_valid = 1; start = 1;
    @(posedge clk); #1;
    start = 0; data_valid = 0;
    @(negedge clk);
    chk("st_seeding", seeding, 1);
    chk("st_pc", pulse_count, 0);
    chk("st_valid", data_out_valid, 0);
    @(posedge clk); #1;
    send(7); send(8); send(9); send(10); send(1);
    drain();
    chk_log("st", '{16'd7, 16'd8, 16'd9, 16'd10, 16'd8});
    // reset mid-run with an output pending
    data_out_ready = 0;
    send(3);
    rst_n = 0;
    @(negedge clk);
    chk("mr_data_out", data_out, 0);
    chk("mr_valid", data_out_valid, 0);
    chk("mr_pc", pulse_count, 0);
    chk("mr_seeding", seeding, 0);
    chk("mr_ready", data_ready, 0);
    @(posedge clk); #1;
    rst_n = 1; data_out_ready = 1; data_valid = 1;
    repeat (3) begin @(negedge clk); chk("mr_idle_ready", data_ready, 0); end
    @(posedge clk); #1;
    data_valid = 0;
    pulse_start();
    @(negedge clk);
    chk("mr_ready_after_start", data_ready, 1);
    @(posedge clk); #1;
`ifdef MTI_INTEG_LEAK_EN
    pulse_start();
    q_log.delete();
    send(160); send(0); send(0); send(0); send(0);
    drain();
    chk("leak_out", q_log.size() > 4 ? q_log[4] : 16'hDEAD, 150);
`endif
    // randomized traffic, checked every cycle by the model
    repeat (3000) begin
      enable = ($urandom % 5) != 0;
      data_valid = $urandom % 2;
      data_out_ready = ($urandom % 10) < 7;
      data_in = 16'($urandom);
      start = ($urandom % 60) == 0;
      @(posedge clk); #1;
    end
    enable = 1; data_valid = 0; start = 0; data_out_ready = 1;
    drain();
    chk("end_drained", data_out_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
